// File: rtl/psg_write_sched.sv
// ---------------------------------------------------------------------------
// psg_write_sched
//   Write scheduler for the jt49 PSG register port. Two requesters share the
//   PSG write bus: A (host CPU bridge) and B (music/init sequencer). The
//   scheduler accepts one command per valid/ready handshake and replays it on
//   the PSG bus with a fixed setup cycle, a WR_HOLD-cycle write strobe and a
//   WR_GAP-cycle idle gap. The PSG therefore latches the same way no matter
//   how the requesters behave.
//
//   Parameters:
//     WR_HOLD    cycles psg_wr_n is held low per write (>=1)
//     WR_GAP     idle cycles after the strobe before the next grant (>=0)
//     PRIORITY_A 0 = round-robin between A and B, 1 = A always wins
//
//   Optional feature, enabled by defining PSG_SCHED_DEDUP_EN:
//     A 16x8 shadow of the last value issued to each PSG register. A command
//     whose data matches the shadow is acknowledged but not issued. Register
//     13 (envelope shape) is always issued, because writing it restarts the
//     envelope.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     a_valid/a_ready       requester A handshake; a_addr/a_data its command
//     b_valid/b_ready       requester B handshake; b_addr/b_data its command
//     psg_addr, psg_din     PSG address/data bus (held from SETUP to end of GAP)
//     psg_cs_n, psg_wr_n    PSG chip select and write strobe (active low)
//     busy                  high whenever the scheduler is not IDLE
// ---------------------------------------------------------------------------
module psg_write_sched #(
  parameter int WR_HOLD    = 2,
  parameter int WR_GAP     = 1,
  parameter int PRIORITY_A = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_data,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  localparam int MAX_CNT = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  // The counter counts down to zero, so a phase of N cycles loads N-1.
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((WR_GAP > 0) ? (WR_GAP - 1) : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             rr_a;       // round-robin pointer: 1 = A is favoured
  logic             grant_a;
  logic             grant_b;
  logic             xfer;
  logic             dup;
  logic             issue;
  logic [3:0]       sel_addr;
  logic [7:0]       sel_data;

  // Arbitration: a lone requester always wins; on contention the fixed
  // priority or the round-robin pointer decides.
  always_comb begin
    grant_a  = a_valid && (!b_valid || (PRIORITY_A != 0) || rr_a);
    grant_b  = b_valid && !grant_a;
    a_ready  = (state == IDLE) && grant_a;
    b_ready  = (state == IDLE) && grant_b;
    xfer     = a_ready || b_ready;
    sel_addr = grant_a ? a_addr : b_addr;
    sel_data = grant_a ? a_data : b_data;
  end

`ifdef PSG_SCHED_DEDUP_EN
  logic [7:0] shadow [16];

  assign dup = (shadow[sel_addr] == sel_data) && (sel_addr != 4'd13);

  // Shadow is written on the edge that enters SETUP, i.e. only for commands
  // that are really issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else if (issue) begin
      shadow[sel_addr] <= sel_data;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A transfer that is a duplicate is acknowledged but leaves the FSM idle.
  assign issue = xfer && !dup;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (cnt == '0) state_nxt = (WR_GAP > 0) ? GAP : IDLE;
      GAP:     if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psg_cs_n = 1'b1;
    psg_wr_n = 1'b1;
    busy     = (state != IDLE);
    case (state)
      SETUP:   psg_cs_n = 1'b0;
      STROBE: begin
        psg_cs_n = 1'b0;
        psg_wr_n = 1'b0;
      end
      default: ;
    endcase
  end

  // Shared phase counter: loaded while in SETUP for the strobe, and reloaded
  // on the last strobe cycle for the gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case (state)
        SETUP:   cnt <= HOLD_LD;
        STROBE:  cnt <= (cnt == '0) ? GAP_LD : cnt - 1'b1;
        GAP:     if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // The pointer moves on every accepted transfer, including dropped ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_a <= 1'b1;
    end else if (a_ready) begin
      rr_a <= 1'b0;
    end else if (b_ready) begin
      rr_a <= 1'b1;
    end
  end

  // PSG bus data is captured only for issued commands so it stays stable
  // through the whole write and keeps its last value while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      psg_addr <= '0;
      psg_din  <= '0;
    end else if (issue) begin
      psg_addr <= sel_addr;
      psg_din  <= sel_data;
    end
  end

endmodule

// File: tb/tb_psg_write_sched.sv
module tb_psg_write_sched;

  localparam int HOLD = 2;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid = 1'b0;
  logic [3:0] a_addr = '0;
  logic [7:0] a_data = '0;
  logic       b_valid = 1'b0;
  logic [3:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       a_ready, b_ready, psg_cs_n, psg_wr_n, busy;
  logic [3:0] psg_addr;
  logic [7:0] psg_din;
  logic       p_a_ready, p_b_ready, p_psg_cs_n, p_psg_wr_n, p_busy;
  logic [3:0] p_psg_addr;
  logic [7:0] p_psg_din;

  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   low_len = 0;
  logic prev_wr_n = 1'b1;
  logic prev_reset = 1'b1;
  cmd_t exp_q[$];
  cmd_t mon_e;

  psg_write_sched #(.WR_HOLD(2), .WR_GAP(1), .PRIORITY_A(0)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .psg_addr(psg_addr), .psg_din(psg_din), .psg_cs_n(psg_cs_n),
    .psg_wr_n(psg_wr_n), .busy(busy)
  );

  psg_write_sched #(.WR_HOLD(2), .WR_GAP(1), .PRIORITY_A(1)) dut_pa (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(p_a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(p_b_ready), .b_addr(b_addr), .b_data(b_data),
    .psg_addr(p_psg_addr), .psg_din(p_psg_din), .psg_cs_n(p_psg_cs_n),
    .psg_wr_n(p_psg_wr_n), .busy(p_busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every falling wr_n edge must match the oldest
  // expected command; every complete strobe must last HOLD cycles.
  always @(negedge clk) begin
    if (prev_wr_n === 1'b1 && psg_wr_n === 1'b0) begin
      pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_pulse_unexpected got addr=%0d din=%02h required no pulse", psg_addr, psg_din);
      end else begin
        mon_e = exp_q.pop_front();
        if ({psg_addr, psg_din} !== {mon_e.addr, mon_e.data}) begin
          bad++;
          $display("FAIL wr_pulse_cmd got addr=%0d din=%02h required addr=%0d din=%02h",
                   psg_addr, psg_din, mon_e.addr, mon_e.data);
        end
      end
    end
    if (prev_wr_n === 1'b0 && psg_wr_n === 1'b1 && prev_reset !== 1'b1) begin
      total++;
      if (low_len != HOLD) begin
        bad++;
        $display("FAIL wr_pulse_width got=%0d required=%0d", low_len, HOLD);
      end
    end
    low_len    = (psg_wr_n === 1'b0) ? low_len + 1 : 0;
    prev_wr_n  = psg_wr_n;
    prev_reset = reset;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send_a(input logic [3:0] ad, input logic [7:0] d, input bit issue, inout int acc);
    bit got = 0;
    a_valid = 1'b1;
    a_addr  = ad;
    a_data  = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (a_ready === 1'b1) begin
        got = 1;
        acc++;
        if (issue) exp_q.push_back({ad, d});
      end
      cyc();
    end
    a_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_a_timeout got no a_ready required a_ready addr=%0d", ad);
    end
  endtask

  task automatic send_b(input logic [3:0] ad, input logic [7:0] d, input bit issue, inout int acc);
    bit got = 0;
    b_valid = 1'b1;
    b_addr  = ad;
    b_data  = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (b_ready === 1'b1) begin
        got = 1;
        acc++;
        if (issue) exp_q.push_back({ad, d});
      end
      cyc();
    end
    b_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_b_timeout got no b_ready required b_ready addr=%0d", ad);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    cyc();
    @(negedge clk);
    total++;
    if (psg_wr_n !== 1'b1) begin bad++; $display("FAIL reset_wr_n got=%b required=1", psg_wr_n); end
    total++;
    if (psg_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b required=1", psg_cs_n); end
    total++;
    if (psg_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got=%0d required=0", psg_addr); end
    total++;
    if (psg_din !== 8'd0) begin bad++; $display("FAIL reset_din got=%02h required=00", psg_din); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b required=0", busy); end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [5:0] er = 6'b100001;
    logic [5:0] eb = 6'b011110;
    logic [5:0] ew = 6'b110011;
    logic [5:0] ec = 6'b110001;
    do_reset();
    a_valid = 1'b1;
    a_addr  = 4'd7;
    a_data  = 8'h38;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (a_ready !== er[c]) begin bad++; $display("FAIL single_a_ready c=%0d got=%b required=%b", c, a_ready, er[c]); end
      total++;
      if (busy !== eb[c]) begin bad++; $display("FAIL single_busy c=%0d got=%b required=%b", c, busy, eb[c]); end
      total++;
      if (psg_wr_n !== ew[c]) begin bad++; $display("FAIL single_wr_n c=%0d got=%b required=%b", c, psg_wr_n, ew[c]); end
      total++;
      if (psg_cs_n !== ec[c]) begin bad++; $display("FAIL single_cs_n c=%0d got=%b required=%b", c, psg_cs_n, ec[c]); end
      if (c >= 1) begin
        total++;
        if ({psg_addr, psg_din} !== {4'd7, 8'h38}) begin
          bad++;
          $display("FAIL single_bus c=%0d got addr=%0d din=%02h required addr=7 din=38", c, psg_addr, psg_din);
        end
      end
      if (c == 0) exp_q.push_back({4'd7, 8'h38});
      if (c == 5) exp_q.push_back({4'd7, 8'h39});
      cyc();
      if (c == 0) a_data = 8'h39;
    end
    a_valid = 1'b0;
    wait_cycles(6);
  endtask

  task automatic test_strobe_reset();
    int p0;
    do_reset();
    a_valid = 1'b1;
    a_addr  = 4'd5;
    a_data  = 8'h55;
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_accept got=%b required=1", a_ready); end
    exp_q.push_back({4'd5, 8'h55});
    cyc();
    a_valid = 1'b0;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (psg_wr_n !== 1'b1) begin bad++; $display("FAIL rst_mid_wr_n got=%b required=1", psg_wr_n); end
    total++;
    if (psg_cs_n !== 1'b1) begin bad++; $display("FAIL rst_mid_cs_n got=%b required=1", psg_cs_n); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b required=0", busy); end
    total++;
    if (psg_addr !== 4'd0) begin bad++; $display("FAIL rst_mid_addr got=%0d required=0", psg_addr); end
    p0 = pulses;
    wait_cycles(8);
    total++;
    if (pulses != p0) begin bad++; $display("FAIL rst_no_resume got=%0d pulses required=%0d", pulses, p0); end
  endtask

  task automatic test_rr_priority();
    int  ka = 0;
    int  kb = 0;
    bit  ea, eb, ea2, eb2;
    do_reset();
    a_valid = 1'b1; a_addr = 4'd13; a_data = 8'hA0;
    b_valid = 1'b1; b_addr = 4'd13; b_data = 8'hB0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      ea  = (c % 5 == 0) && (c < 20) && ((c / 5) % 2 == 0);
      eb  = (c % 5 == 0) && (((c / 5) % 2 == 1) || (c == 20));
      ea2 = (c % 5 == 0) && (c < 20);
      eb2 = (c == 20);
      total++;
      if (a_ready !== ea) begin bad++; $display("FAIL rr_a_ready c=%0d got=%b required=%b", c, a_ready, ea); end
      total++;
      if (b_ready !== eb) begin bad++; $display("FAIL rr_b_ready c=%0d got=%b required=%b", c, b_ready, eb); end
      total++;
      if (p_a_ready !== ea2) begin bad++; $display("FAIL pri_a_ready c=%0d got=%b required=%b", c, p_a_ready, ea2); end
      total++;
      if (p_b_ready !== eb2) begin bad++; $display("FAIL pri_b_ready c=%0d got=%b required=%b", c, p_b_ready, eb2); end
      if (ea) exp_q.push_back({4'd13, 8'(8'hA0 + ka)});
      if (eb) exp_q.push_back({4'd13, 8'(8'hB0 + kb)});
      cyc();
      if (ea) begin ka++; a_data = 8'(8'hA0 + ka); end
      if (eb) begin kb++; b_data = 8'(8'hB0 + kb); end
      if (c == 19) a_valid = 1'b0;
    end
    b_valid = 1'b0;
    wait_cycles(8);
  endtask

  task automatic test_collision();
    bit ea, eb;
    do_reset();
    a_valid = 1'b1; a_addr = 4'd2; a_data = 8'h21;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      ea = (c == 0) || (c == 10);
      eb = (c == 5);
      total++;
      if (a_ready !== ea) begin bad++; $display("FAIL coll_a_ready c=%0d got=%b required=%b", c, a_ready, ea); end
      total++;
      if (b_ready !== eb) begin bad++; $display("FAIL coll_b_ready c=%0d got=%b required=%b", c, b_ready, eb); end
      if (c == 0)  exp_q.push_back({4'd2, 8'h21});
      if (c == 5)  exp_q.push_back({4'd3, 8'h31});
      if (c == 10) exp_q.push_back({4'd2, 8'h22});
      cyc();
      if (c == 0) a_valid = 1'b0;
      if (c == 1) begin
        a_valid = 1'b1; a_data = 8'h22;
        b_valid = 1'b1; b_addr = 4'd3; b_data = 8'h31;
      end
      if (c == 5)  b_valid = 1'b0;
      if (c == 10) a_valid = 1'b0;
    end
    wait_cycles(6);
  endtask

  task automatic test_dedup();
    int p0;
    int acc = 0;
    int exp_p;
    bit dd;
`ifdef PSG_SCHED_DEDUP_EN
    dd = 1'b1;
`else
    dd = 1'b0;
`endif
    do_reset();
    p0 = pulses;
    send_a(4'd0, 8'd40, 1'b1, acc);
    send_a(4'd0, 8'd40, !dd, acc);
    send_a(4'd13, 8'd14, 1'b1, acc);
    send_a(4'd13, 8'd14, 1'b1, acc);
    wait_cycles(8);
    exp_p = dd ? 3 : 4;
    total++;
    if (acc != 4) begin bad++; $display("FAIL dedup_ready_count got=%0d required=4", acc); end
    total++;
    if (pulses - p0 != exp_p) begin bad++; $display("FAIL dedup_pulse_count got=%0d required=%0d", pulses - p0, exp_p); end
  endtask

  task automatic test_stream();
    logic [3:0] sa [8] = '{4'd11, 4'd12, 4'd0, 4'd1, 4'd8, 4'd6, 4'd13, 4'd7};
    logic [7:0] sd [8] = '{8'd120, 8'd0, 8'd40, 8'd0, 8'd48, 8'd1, 8'd14, 8'd8};
    logic [7:0] sh [16];
    int  p0;
    int  acc = 0;
    int  n_issue = 0;
    bit  iss;
    for (int i = 0; i < 16; i++) sh[i] = 8'd0;
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      iss = 1'b1;
`ifdef PSG_SCHED_DEDUP_EN
      iss = !((sh[sa[i]] == sd[i]) && (sa[i] != 4'd13));
`endif
      if (iss) begin
        sh[sa[i]] = sd[i];
        n_issue++;
      end
      send_b(sa[i], sd[i], iss, acc);
    end
    wait_cycles(8);
    total++;
    if (acc != 8) begin bad++; $display("FAIL stream_ready_count got=%0d required=8", acc); end
    total++;
    if (pulses - p0 != n_issue) begin bad++; $display("FAIL stream_pulse_count got=%0d required=%0d", pulses - p0, n_issue); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_strobe_reset();
    test_rr_priority();
    test_collision();
    test_dedup();
    test_stream();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
